// File: rtl/cmsdk_apb_async_pkg.sv
// -----------------------------------------------------------------------------
// cmsdk_apb_async_pkg
// Shared definitions for the APB-side controller of the AHB-to-APB async
// bridge: FSM state encoding, default ACCESS wait limit, and small helpers
// that zero a data/strobe field when it does not apply to the transfer
// direction.
// -----------------------------------------------------------------------------
package cmsdk_apb_async_pkg;

   // APB transfer phases; 2-bit encoding is fixed so that waveforms and
   // downstream debug tooling read the same values everywhere.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETUP  = 2'b01,
      ST_ACCESS = 2'b10,
      ST_DONE   = 2'b11
   } apb_state_t;

   // Default number of enabled ACCESS cycles to wait for pready.
   localparam int TIMEOUT_CYCLES_DEFAULT = 256;

   // Timeout counter width; covers the full 2..65535 limit range.
   localparam int TMO_CNT_WIDTH = 16;

   // Pass data through when keep=1, otherwise return all zeros.
   function automatic logic [31:0] sel_data(input logic keep, input logic [31:0] data);
      return keep ? data : 32'h0000_0000;
   endfunction

   // Pass byte strobes through when keep=1, otherwise return all zeros.
   function automatic logic [3:0] sel_strb(input logic keep, input logic [3:0] strb);
      return keep ? strb : 4'h0;
   endfunction

endpackage

// File: rtl/cmsdk_ahb_to_apb_async_syn.sv
// -----------------------------------------------------------------------------
// cmsdk_ahb_to_apb_async_syn
// Two-flop synchronizer with clock enable for a single-bit level crossing
// into the clk domain.
//   clk    : destination clock
//   resetn : asynchronous active-low reset, clears both flops
//   en     : clock enable; both flops advance only when 1
//   d      : asynchronous input level
//   q      : synchronized output level
// -----------------------------------------------------------------------------
module cmsdk_ahb_to_apb_async_syn (
   input  logic clk,
   input  logic resetn,
   input  logic en,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage resynchronization; first stage may go metastable.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else if (en) begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/cmsdk_apb_async_slv_ctrl.sv
// -----------------------------------------------------------------------------
// cmsdk_apb_async_slv_ctrl
// APB-domain half of the AHB-to-APB asynchronous bridge. Receives a 4-phase
// request from the AHB domain, runs one APB transfer (SETUP then ACCESS) and
// returns the response with a 4-phase acknowledge.
//
// Optional feature macro: APB_ASYNC_TIMEOUT_EN
//   When defined, an ACCESS phase that sees pready=0 for TIMEOUT_CYCLES
//   enabled cycles is terminated with rsp_err=1. When undefined, ACCESS waits
//   for pready indefinitely and no counter exists.
//
// Parameters
//   ADDR_WIDTH     : APB address width
//   TIMEOUT_CYCLES : ACCESS wait limit (2..65535), used only with the macro
//
// Ports
//   clk, resetn         : APB clock, asynchronous active-low reset
//   pclken              : clock enable; all registers advance only when 1
//   req_async           : request level from AHB domain (unsynchronized)
//   ack                 : acknowledge level to AHB domain (registered)
//   txn_addr/txn_write/txn_wdata/txn_strb : payload, stable while requested
//   rsp_rdata/rsp_err   : response, valid while ack=1
//   paddr..pstrb        : APB master outputs (registered)
//   prdata/pready/pslverr : APB slave response inputs
// -----------------------------------------------------------------------------
module cmsdk_apb_async_slv_ctrl
   import cmsdk_apb_async_pkg::*;
#(
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  pclken,
   input  logic                  req_async,
   output logic                  ack,
   input  logic [ADDR_WIDTH-1:0] txn_addr,
   input  logic                  txn_write,
   input  logic [31:0]           txn_wdata,
   input  logic [3:0]            txn_strb,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [31:0]           pwdata,
   output logic [3:0]            pstrb,
   input  logic [31:0]           prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   // Reject out-of-range limits at elaboration.
   if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
      $error("cmsdk_apb_async_slv_ctrl: TIMEOUT_CYCLES must be 2..65535");
   end

   apb_state_t state;
   logic       req_s;

`ifdef APB_ASYNC_TIMEOUT_EN
   // Counter value seen on the cycle that reaches the limit.
   localparam logic [TMO_CNT_WIDTH-1:0] TMO_LAST = TMO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   logic [TMO_CNT_WIDTH-1:0] tmo_cnt;
`endif

   // The only consumer of req_async; everything else uses req_s.
   cmsdk_ahb_to_apb_async_syn u_req_syn (
      .clk    (clk),
      .resetn (resetn),
      .en     (pclken),
      .d      (req_async),
      .q      (req_s)
   );

   // Transfer FSM with all APB and handshake outputs registered.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         ack       <= 1'b0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= {ADDR_WIDTH{1'b0}};
         pwdata    <= 32'h0000_0000;
         pstrb     <= 4'h0;
         rsp_rdata <= 32'h0000_0000;
         rsp_err   <= 1'b0;
`ifdef APB_ASYNC_TIMEOUT_EN
         tmo_cnt   <= {TMO_CNT_WIDTH{1'b0}};
`endif
      end else if (pclken) begin
         case (state)
            ST_IDLE: begin
               // ack is already 0 here, so a new request is a new transfer.
               if (req_s) begin
                  state   <= ST_SETUP;
                  psel    <= 1'b1;
                  penable <= 1'b0;
                  paddr   <= txn_addr;
                  pwrite  <= txn_write;
                  pwdata  <= sel_data(txn_write, txn_wdata);
                  pstrb   <= sel_strb(txn_write, txn_strb);
               end
            end

            ST_SETUP: begin
               state   <= ST_ACCESS;
               penable <= 1'b1;
`ifdef APB_ASYNC_TIMEOUT_EN
               tmo_cnt <= {TMO_CNT_WIDTH{1'b0}};
`endif
            end

            ST_ACCESS: begin
               // A late req_s fall is not looked at here; the transfer
               // always completes and DONE then exits straight away.
               if (pready) begin
                  state     <= ST_DONE;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  ack       <= 1'b1;
                  rsp_err   <= pslverr;
                  rsp_rdata <= sel_data(!pwrite, prdata);
               end
`ifdef APB_ASYNC_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  // Limit reached without pready: abandon with an error.
                  state     <= ST_DONE;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  ack       <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= 32'h0000_0000;
               end else begin
                  tmo_cnt <= tmo_cnt + {{(TMO_CNT_WIDTH-1){1'b0}}, 1'b1};
               end
`else
               else begin
                  state <= ST_ACCESS;
               end
`endif
            end

            ST_DONE: begin
               if (!req_s) begin
                  state <= ST_IDLE;
                  ack   <= 1'b0;
               end
            end

            default: begin
               state   <= ST_IDLE;
               ack     <= 1'b0;
               psel    <= 1'b0;
               penable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmsdk_apb_async_slv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cmsdk_apb_async_slv_ctrl
// Self-checking bench: a behavioural model predicts every output each cycle,
// and directed sequences pin latencies and response values with literals.
// Build with or without APB_ASYNC_TIMEOUT_EN; the DUT uses TIMEOUT_CYCLES=4.
// -----------------------------------------------------------------------------
module tb_cmsdk_apb_async_slv_ctrl;

   localparam int AW  = 16;
   localparam int TMO = 4;

   logic          clk;
   logic          resetn;
   logic          pclken;
   logic          req_async;
   logic          ack;
   logic [AW-1:0] txn_addr;
   logic          txn_write;
   logic [31:0]   txn_wdata;
   logic [3:0]    txn_strb;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] paddr;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [31:0]   pwdata;
   logic [3:0]    pstrb;
   logic [31:0]   prdata;
   logic          pready;
   logic          pslverr;

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   cmsdk_apb_async_slv_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .pclken    (pclken),
      .req_async (req_async),
      .ack       (ack),
      .txn_addr  (txn_addr),
      .txn_write (txn_write),
      .txn_wdata (txn_wdata),
      .txn_strb  (txn_strb),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .paddr     (paddr),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // req seen through two enabled-cycle delay; phase: 0 idle, 1 setup,
   // 2 access, 3 response held.
   logic          m_d1, m_d2;
   int            m_phase, m_waits;
   logic          m_ack, m_psel, m_pen, m_pwrite, m_err;
   logic [AW-1:0] m_paddr;
   logic [31:0]   m_pwdata, m_rdata;
   logic [3:0]    m_pstrb;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_d1 <= 1'b0; m_d2 <= 1'b0; m_phase <= 0; m_waits <= 0;
         m_ack <= 1'b0; m_psel <= 1'b0; m_pen <= 1'b0; m_pwrite <= 1'b0;
         m_err <= 1'b0; m_paddr <= '0; m_pwdata <= 32'h0; m_rdata <= 32'h0;
         m_pstrb <= 4'h0;
      end else if (pclken) begin
         m_d1 <= req_async;
         m_d2 <= m_d1;
         if (m_phase == 0 && m_d2) begin
            m_phase <= 1; m_psel <= 1'b1; m_pen <= 1'b0;
            m_paddr <= txn_addr; m_pwrite <= txn_write;
            m_pwdata <= txn_write ? txn_wdata : 32'h0;
            m_pstrb  <= txn_write ? txn_strb : 4'h0;
         end else if (m_phase == 1) begin
            m_phase <= 2; m_pen <= 1'b1; m_waits <= 0;
         end else if (m_phase == 2) begin
            if (pready) begin
               m_phase <= 3; m_psel <= 1'b0; m_pen <= 1'b0; m_ack <= 1'b1;
               m_err <= pslverr; m_rdata <= m_pwrite ? 32'h0 : prdata;
            end
`ifdef APB_ASYNC_TIMEOUT_EN
            else if (m_waits + 1 >= TMO) begin
               m_phase <= 3; m_psel <= 1'b0; m_pen <= 1'b0; m_ack <= 1'b1;
               m_err <= 1'b1; m_rdata <= 32'h0;
            end
`endif
            else m_waits <= m_waits + 1;
         end else if (m_phase == 3 && !m_d2) begin
            m_phase <= 0; m_ack <= 1'b0;
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         check("m_ack", {31'h0, ack}, {31'h0, m_ack});
         check("m_psel", {31'h0, psel}, {31'h0, m_psel});
         check("m_penable", {31'h0, penable}, {31'h0, m_pen});
         check("m_pwrite", {31'h0, pwrite}, {31'h0, m_pwrite});
         check("m_paddr", {16'h0, paddr}, {16'h0, m_paddr});
         check("m_pwdata", pwdata, m_pwdata);
         check("m_pstrb", {28'h0, pstrb}, {28'h0, m_pstrb});
         if (m_ack) begin
            check("m_rsp_rdata", rsp_rdata, m_rdata);
            check("m_rsp_err", {31'h0, rsp_err}, {31'h0, m_err});
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One enabled edge followed by one frozen edge.
   task automatic en_step();
      pclken = 1'b1;
      @(posedge clk);
      #1;
      pclken = 1'b0;
      @(posedge clk);
      #1;
      pclken = 1'b1;
   endtask

   function automatic logic get_sig(input int sel);
      case (sel)
         0:       return psel;
         1:       return penable;
         default: return ack;
      endcase
   endfunction

   // Steps until the selected output equals val; n = steps taken (bounded).
   task automatic wait_sig(input int sel, input logic val, input int bound, output int n);
      n = 0;
      while (get_sig(sel) !== val && n < bound) begin
         step();
         n++;
      end
   endtask

   task automatic wait_sig_en(input int sel, input logic val, input int bound, output int n);
      n = 0;
      while (get_sig(sel) !== val && n < bound) begin
         en_step();
         n++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ack_hits;
      resetn = 1'b0; pclken = 1'b1; req_async = 1'b0;
      txn_addr = 16'h0; txn_write = 1'b0; txn_wdata = 32'h0; txn_strb = 4'h0;
      prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
      repeat (3) step();
      chk_on = 1'b1;
      check("rst_ack", {31'h0, ack}, 32'h0);
      check("rst_psel", {31'h0, psel}, 32'h0);
      check("rst_penable", {31'h0, penable}, 32'h0);
      check("rst_paddr", {16'h0, paddr}, 32'h0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      resetn = 1'b1;
      step();

      // Read, zero wait states.
      txn_addr = 16'h0040; txn_write = 1'b0; prdata = 32'hCAFEF00D;
      pready = 1'b1; pslverr = 1'b0; req_async = 1'b1;
      wait_sig(0, 1'b1, 10, n);
      check("rd_req_to_psel", n, 3);
      check("rd_paddr", {16'h0, paddr}, 32'h0000_0040);
      check("rd_penable_setup", {31'h0, penable}, 32'h0);
      step();
      check("rd_penable_access", {31'h0, penable}, 32'h1);
      step();
      check("rd_ack", {31'h0, ack}, 32'h1);
      check("rd_rdata", rsp_rdata, 32'hCAFEF00D);
      check("rd_err", {31'h0, rsp_err}, 32'h0);
      check("rd_psel_done", {31'h0, psel}, 32'h0);
      req_async = 1'b0;
      wait_sig(2, 1'b0, 10, n);
      check("rd_ack_fall", n, 3);

      // Write with three wait states and a slave error.
      txn_addr = 16'h0104; txn_write = 1'b1; txn_wdata = 32'h12345678;
      txn_strb = 4'hF; prdata = 32'hDEADBEEF; pready = 1'b0; req_async = 1'b1;
      wait_sig(0, 1'b1, 10, n);
      check("wr_req_to_psel", n, 3);
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         check("wr_wait_penable", {31'h0, penable}, 32'h1);
         check("wr_wait_pwdata", pwdata, 32'h12345678);
         check("wr_wait_pstrb", {28'h0, pstrb}, 32'h0000_000F);
         check("wr_wait_ack", {31'h0, ack}, 32'h0);
      end
      pready = 1'b1; pslverr = 1'b1;
      step();
      check("wr_ack", {31'h0, ack}, 32'h1);
      check("wr_err", {31'h0, rsp_err}, 32'h1);
      check("wr_rdata_zero", rsp_rdata, 32'h0);
      pready = 1'b0; pslverr = 1'b0; req_async = 1'b0;
      wait_sig(2, 1'b0, 10, n);
      check("wr_ack_fall", n, 3);

      // Read with pclken toggling; pready=1 on frozen ACCESS edge is ignored.
      txn_addr = 16'h0080; txn_write = 1'b0; prdata = 32'h0BADF00D;
      pready = 1'b1; req_async = 1'b1;
      wait_sig_en(0, 1'b1, 10, n);
      check("en_req_to_psel", n, 3);
      check("en_pwdata_read", pwdata, 32'h0);
      check("en_pstrb_read", {28'h0, pstrb}, 32'h0);
      en_step();
      check("en_penable_frozen", {31'h0, penable}, 32'h1);
      check("en_ack_frozen", {31'h0, ack}, 32'h0);
      en_step();
      check("en_ack", {31'h0, ack}, 32'h1);
      check("en_rdata", rsp_rdata, 32'h0BADF00D);
      req_async = 1'b0;
      wait_sig_en(2, 1'b0, 10, n);
      check("en_ack_fall", n, 3);

      // pready stuck low.
      txn_addr = 16'h0200; txn_write = 1'b0; prdata = 32'h55AA55AA;
      pready = 1'b0; req_async = 1'b1;
      wait_sig(0, 1'b1, 10, n);
      check("to_req_to_psel", n, 3);
      step();
`ifdef APB_ASYNC_TIMEOUT_EN
      wait_sig(2, 1'b1, 20, n);
      check("to_access_cycles", n, TMO);
      check("to_err", {31'h0, rsp_err}, 32'h1);
      check("to_rdata_zero", rsp_rdata, 32'h0);
      check("to_psel", {31'h0, psel}, 32'h0);
`else
      ack_hits = 0;
      repeat (1000) begin
         step();
         if (ack !== 1'b0) ack_hits++;
      end
      check("noto_ack_hits", ack_hits, 0);
      check("noto_psel_held", {31'h0, psel}, 32'h1);
      pready = 1'b1;
      step();
      check("noto_ack", {31'h0, ack}, 32'h1);
      check("noto_rdata", rsp_rdata, 32'h55AA55AA);
`endif
      pready = 1'b0; req_async = 1'b0;
      wait_sig(2, 1'b0, 10, n);
      check("to_ack_fall", n, 3);

      // Reset during ACCESS, request kept high.
      txn_addr = 16'h0300; txn_write = 1'b1; txn_wdata = 32'hA5A5A5A5;
      txn_strb = 4'h3; pready = 1'b0; req_async = 1'b1;
      wait_sig(0, 1'b1, 10, n);
      step();
      #3;
      resetn = 1'b0;
      #1;
      check("rst_mid_psel", {31'h0, psel}, 32'h0);
      check("rst_mid_penable", {31'h0, penable}, 32'h0);
      check("rst_mid_ack", {31'h0, ack}, 32'h0);
      check("rst_mid_pwdata", pwdata, 32'h0);
      check("rst_mid_paddr", {16'h0, paddr}, 32'h0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      wait_sig(0, 1'b1, 10, n);
      check("rst_restart", n, 3);
      pready = 1'b1;
      step();
      step();
      check("rst_restart_ack", {31'h0, ack}, 32'h1);
      check("rst_restart_rdata", rsp_rdata, 32'h0);
      pready = 1'b0; req_async = 1'b0;
      wait_sig(2, 1'b0, 10, n);
      check("rst_restart_fall", n, 3);

      // Request withdrawn during SETUP/ACCESS: transfer completes, DONE exits next cycle.
      txn_addr = 16'h0044; txn_write = 1'b0; prdata = 32'h01234567;
      pready = 1'b0; req_async = 1'b1;
      wait_sig(0, 1'b1, 10, n);
      req_async = 1'b0;
      step();
      step();
      step();
      check("early_no_ack", {31'h0, ack}, 32'h0);
      pready = 1'b1;
      step();
      check("early_ack", {31'h0, ack}, 32'h1);
      check("early_rdata", rsp_rdata, 32'h01234567);
      pready = 1'b0;
      wait_sig(2, 1'b0, 10, n);
      check("early_ack_fall", n, 1);

      repeat (2) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
